rsc_viterbi_decoder: RTL and testbench

Hard-decision Viterbi decoder for one constituent 8-state RSC code of the NB-IoT turbo encoder. It is the receive-side counterpart of the encoder's shift-register datapath. It takes 43 received (systematic, parity) bit pairs per frame: 40 information steps plus 3 trellis-termination steps. It returns the 40 decoded information bits as a parallel word, together with a path-metric error count. The block serves as the loopback/verification decoder for the uplink turbo encoder chain.

---
 rtl/turbo_pkg.sv | 33 +++
 rtl/rsc_acs_unit.sv | 39 +++
 rtl/rsc_viterbi_decoder.sv | 139 +++++++++++++
 tb/tb_rsc_viterbi_decoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// Shared constants, FSM encoding and RSC trellis helpers for the turbo encoder/decoder chain.
// Constituent code: state {s1,s2,s3}, feedback a = u^s2^s3, parity z = a^s1^s3.
package turbo_pkg;

  localparam int unsigned K       = 40;
  localparam int unsigned TAIL    = 3;
  localparam int unsigned NSTEPS  = K + TAIL;
  localparam int unsigned NSTATES = 8;
  localparam int unsigned PMW     = 8;

  localparam logic [PMW-1:0] PM_INIT = 8'd64;
  localparam logic [PMW-1:0] PM_MAX  = 8'd255;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACS,
    S_TRACE,
    S_DONE
  } vit_state_e;

  function automatic logic [2:0] rsc_next_state(input logic [2:0] state, input logic u);
    logic a;
    a = u ^ state[1] ^ state[0];
    return {a, state[2], state[1]};
  endfunction

  function automatic logic rsc_parity(input logic [2:0] state, input logic u);
    logic a;
    a = u ^ state[1] ^ state[0];
    return a ^ state[2] ^ state[0];
  endfunction

endpackage

// File: rtl/rsc_acs_unit.sv
// Add-compare-select for one trellis state: picks the cheaper of its two predecessors.
// Sums saturate at PM_MAX so the all-ones tail fill cannot wrap to a small metric.
module rsc_acs_unit
  import turbo_pkg::*;
#(
  parameter logic [2:0] STATE = 3'd0
) (
  input  logic [PMW-1:0] pm0_i,
  input  logic [PMW-1:0] pm1_i,
  input  logic           sys_i,
  input  logic           par_i,
  output logic [PMW-1:0] pm_o,
  output logic           dec_o
);

  logic       u0;
  logic       z0;
  logic [1:0] bm0;
  logic [1:0] bm1;
  logic [PMW:0]   sum0;
  logic [PMW:0]   sum1;
  logic [PMW-1:0] sat0;
  logic [PMW-1:0] sat1;

  always_comb begin
    u0   = STATE[2] ^ STATE[0];
    z0   = STATE[2] ^ STATE[1];
    bm0  = {1'b0, sys_i ^ u0} + {1'b0, par_i ^ z0};
    // The d=1 branch carries the complemented labels, so its distance is 2-bm0.
    bm1  = 2'd2 - bm0;
    sum0 = {1'b0, pm0_i} + {{(PMW-1){1'b0}}, bm0};
    sum1 = {1'b0, pm1_i} + {{(PMW-1){1'b0}}, bm1};
    sat0 = sum0[PMW] ? '1 : sum0[PMW-1:0];
    sat1 = sum1[PMW] ? '1 : sum1[PMW-1:0];
    dec_o = (sat1 < sat0);
    pm_o  = dec_o ? sat1 : sat0;
  end

endmodule

// File: rtl/rsc_viterbi_decoder.sv
// Hard-decision Viterbi decoder for one 8-state RSC constituent code (40 info + 3 tail steps).
// Parallel ACS per step, full survivor memory, traceback from state 0 after the last pair.
module rsc_viterbi_decoder
  import turbo_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           in_valid,
  input  logic           sys,
  input  logic           par,
  output logic           busy,
  output logic           done,
  output logic [K-1:0]   dout,
  output logic [PMW-1:0] err_metric
);

  vit_state_e state_q, state_d;
  logic [5:0]         step_q, step_d;
  logic [2:0]         tb_q, tb_d;
  logic [K-1:0]       dec_q, dec_d;
  logic [K-1:0]       dout_q, dout_d;
  logic [PMW-1:0]     err_q, err_d;
  logic               done_q, done_d;
  logic [PMW-1:0]     pm_q [NSTATES];
  logic [PMW-1:0]     pm_d [NSTATES];
  logic [PMW-1:0]     acs_pm [NSTATES];
  logic [NSTATES-1:0] acs_dec;
  logic [NSTATES-1:0] surv_q [NSTEPS];
  logic               surv_wr;
  logic               is_tail;
  logic               tb_dec;
  logic               tb_u;

  for (genvar n = 0; n < NSTATES; n++) begin : g_acs
    rsc_acs_unit #(.STATE(3'(n))) u_acs (
      .pm0_i (pm_q[(n % 4) * 2]),
      .pm1_i (pm_q[(n % 4) * 2 + 1]),
      .sys_i (sys),
      .par_i (par),
      .pm_o  (acs_pm[n]),
      .dec_o (acs_dec[n])
    );
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tb_d    = tb_q;
    dec_d   = dec_q;
    dout_d  = dout_q;
    err_d   = err_q;
    done_d  = 1'b0;
    pm_d    = pm_q;
    surv_wr = 1'b0;
    is_tail = (step_q >= 6'(K));
    tb_dec  = surv_q[step_q][tb_q];
    tb_u    = tb_q[2] ^ tb_q[0] ^ tb_dec;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACS;
          step_d  = '0;
          for (int unsigned n = 0; n < NSTATES; n++) begin
            pm_d[n] = (n == 0) ? '0 : PM_INIT;
          end
        end
      end
      S_ACS: begin
        if (in_valid) begin
          surv_wr = 1'b1;
          // Tail steps force a=0: states with s1=1 become unreachable.
          for (int unsigned n = 0; n < NSTATES; n++) begin
            pm_d[n] = (is_tail && n >= 4) ? PM_MAX : acs_pm[n];
          end
          if (step_q == 6'(NSTEPS - 1)) begin
            state_d = S_TRACE;
            tb_d    = '0;
          end else begin
            step_d = step_q + 6'd1;
          end
        end
      end
      S_TRACE: begin
        tb_d = {tb_q[1:0], tb_dec};
        if (!is_tail) begin
          dec_d[6'(K - 1) - step_q] = tb_u;
        end
        if (step_q == '0) begin
          state_d = S_DONE;
        end else begin
          step_d = step_q - 6'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        dout_d  = dec_q;
        err_d   = pm_q[0];
        step_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      tb_q    <= '0;
      dec_q   <= '0;
      dout_q  <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      for (int unsigned n = 0; n < NSTATES; n++) begin
        pm_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tb_q    <= tb_d;
      dec_q   <= dec_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pm_q    <= pm_d;
      if (surv_wr) begin
        surv_q[step_q] <= acs_dec;
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign dout       = dout_q;
  assign err_metric = err_q;

endmodule

// File: tb/tb_rsc_viterbi_decoder.sv
// Directed bench: frames encoded by a reference RSC encoder, optional bit flips, known answers.
module tb_rsc_viterbi_decoder;
  import turbo_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           in_valid;
  logic           sys;
  logic           par;
  logic           busy;
  logic           done;
  logic [K-1:0]   dout;
  logic [PMW-1:0] err_metric;

  int checks = 0;
  int errors = 0;

  rsc_viterbi_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .sys        (sys),
    .par        (par),
    .busy       (busy),
    .done       (done),
    .dout       (dout),
    .err_metric (err_metric)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] frame;
    logic [42:0] sflip;
    logic [42:0] pflip;
    logic [39:0] exp_dout;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic encode(input logic [39:0] frame, input logic [42:0] sf, input logic [42:0] pf,
                        output logic [42:0] sv, output logic [42:0] pv);
    logic [2:0] s;
    logic       u;
    s = 3'd0;
    for (int i = 0; i < 43; i++) begin
      if (i < 40) u = frame[39 - i];
      else        u = s[1] ^ s[0];
      sv[i] = u ^ sf[i];
      pv[i] = rsc_parity(s, u) ^ pf[i];
      s     = rsc_next_state(s, u);
    end
  endtask

  // gapped: each pair preceded by two idle cycles carrying junk; restart re-pulses start mid-frame
  task automatic run_frame(input string nm, input logic [39:0] frame, input logic [42:0] sf,
                           input logic [42:0] pf, input logic [39:0] exp_dout,
                           input logic [7:0] exp_err, input bit gapped);
    logic [42:0] sv, pv;
    int lat;
    encode(frame, sf, pf, sv, pv);
    start = 1'b1; in_valid = 1'b1; sys = 1'b1; par = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk({nm, "_busy_rise"}, 64'(busy), 64'd1);
    for (int i = 0; i < 43; i++) begin
      if (gapped) begin
        for (int g = 0; g < 2; g++) begin
          in_valid = 1'b0; sys = ~sv[i]; par = ~pv[i];
          start = (i == 20 && g == 0);
          tick();
          start = 1'b0;
        end
        if (i == 20) chk({nm, "_busy_held"}, 64'(busy), 64'd1);
      end
      in_valid = 1'b1; sys = sv[i]; par = pv[i];
      tick();
    end
    in_valid = 1'b0; sys = 1'b0; par = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      tick();
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd44);
    chk({nm, "_dout"}, 64'(dout), 64'(exp_dout));
    chk({nm, "_err"}, 64'(err_metric), 64'(exp_err));
    chk({nm, "_busy_fall"}, 64'(busy), 64'd0);
    tick();
    chk({nm, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; sys = 1'b0; par = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_err", 64'(err_metric), 64'd0);

    vecs[0] = '{40'h0,          43'h0,           43'h0,           40'h0,          8'd0};
    vecs[1] = '{40'h5555555555, 43'h0,           43'h0,           40'h5555555555, 8'd0};
    vecs[2] = '{40'h5555555555, 43'h0,           43'h1 << 10,     40'h5555555555, 8'd1};
    vecs[3] = '{40'h5555555555, 43'h1,           43'h1 << 25,     40'h5555555555, 8'd2};
    vecs[4] = '{40'hFFFFFFFFFF, 43'h0,           43'h1 << 39,     40'hFFFFFFFFFF, 8'd1};
    for (int v = 0; v < 5; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].frame, vecs[v].sflip, vecs[v].pflip,
                vecs[v].exp_dout, vecs[v].exp_err, 1'b0);
    end

    run_frame("gapped", 40'hC3A51E967B, 43'h0, 43'h0, 40'hC3A51E967B, 8'd0, 1'b1);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 21; i++) begin
      in_valid = 1'b1; sys = 1'b0; par = 1'b0;
      tick();
    end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_dout", 64'(dout), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; sys = 1'b0; par = 1'b0;
      tick();
      if (done) done_seen++;
    end
    in_valid = 1'b0;
    chk("abort_no_done", 64'(done_seen), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);

    run_frame("after_abort", 40'h5555555555, 43'h0, 43'h0, 40'h5555555555, 8'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
